lockin_averager: RTL and testbench

LOCKIN_AVERAGER -- requirements
Module: lockin_averager

---
 rtl/lockin_averager.sv | 131 +++++++++++++
 tb/tb_lockin_averager.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lockin_averager.sv
// Lock-in averager: boxcar-averages the demodulated X/Y streams over 2^L
// samples. Each result is the floor of the window sum shifted right by L,
// registered one clock after the closing sample.

// One averaging lane: accumulator plus output register.
module lockin_lane #(
  parameter int DW = 32,
  parameter int AW = 47,
  parameter int SW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          first,   // sample opens a window: load instead of add
  input  logic          take,    // sample accepted, window stays open
  input  logic          close,   // sample accepted, window closes
  input  logic [SW-1:0] shift,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic signed [AW-1:0] acc_q, acc_d, ext, sum;
  logic signed [DW-1:0] avg_q, avg_d;

  // Sign-extend, then load or accumulate; the closing sample is folded in
  // combinationally so no extra cycle is spent on the result.
  always_comb begin
    ext   = {{(AW-DW){din[DW-1]}}, din};
    sum   = (first ? '0 : acc_q) + ext;
    acc_d = take ? sum : acc_q;
    avg_d = close ? DW'(sum >>> shift) : avg_q;
  end

  // Accumulator and held result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      avg_q <= avg_d;
    end
  end

  assign dout = avg_q;
endmodule

module lockin_averager #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_AVG_LOG2 = 15
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
  input  logic [DATA_WIDTH-1:0]             mixed_x,
  input  logic [DATA_WIDTH-1:0]             mixed_y,
  input  logic                              mixed_valid,
  output logic [DATA_WIDTH-1:0]             averaged_x,
  output logic [DATA_WIDTH-1:0]             averaged_y,
  output logic                              average_valid
);
  localparam int NUM_LANES = 2;
  localparam int LW = $clog2(MAX_AVG_LOG2+1);
  localparam int CW = MAX_AVG_LOG2 + 1;
  localparam int AW = DATA_WIDTH + MAX_AVG_LOG2;

  logic [CW-1:0] cnt_q, cnt_d, n_m1;
  logic [LW-1:0] l_q, l_d, l_eff;
  logic          vld_q, vld_d;
  logic          accept, first, last, take, close;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] din_l, dout_l;

  // Shared window control: rate latched on the first sample, counter wraps
  // after the N-th, and enable low drops any partial window.
  always_comb begin
    accept = enable & mixed_valid;
    first  = (cnt_q == '0);
    l_eff  = l_q;
    if (first)
      l_eff = (avg_log2 > LW'(MAX_AVG_LOG2)) ? LW'(MAX_AVG_LOG2) : avg_log2;
    n_m1   = (CW'(1) << l_eff) - CW'(1);
    last   = (cnt_q == n_m1);
    take   = accept & ~last;
    close  = accept & last;
    cnt_d  = cnt_q;
    l_d    = l_q;
    vld_d  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (accept) begin
      l_d   = l_eff;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      vld_d = last;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      l_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      l_q   <= l_d;
      vld_q <= vld_d;
    end
  end

  assign din_l[0] = mixed_x;
  assign din_l[1] = mixed_y;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lockin_lane #(.DW(DATA_WIDTH), .AW(AW), .SW(LW)) u_lane (
        .clock   (clock),
        .reset_n (reset_n),
        .first   (first),
        .take    (take),
        .close   (close),
        .shift   (l_eff),
        .din     (din_l[g]),
        .dout    (dout_l[g])
      );
    end
  endgenerate

  assign averaged_x    = dout_l[0];
  assign averaged_y    = dout_l[1];
  assign average_valid = vld_q;
endmodule

// File: tb/tb_lockin_averager.sv
// Bench for lockin_averager: directed scenarios then random traffic, all
// checked against a window-queue reference model.
module tb_lockin_averager;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  avg_log2 = '0;
  logic [31:0] mixed_x = '0, mixed_y = '0;
  logic        mixed_valid = 1'b0;
  logic [31:0] averaged_x, averaged_y;
  logic        average_valid;

  int n_cmp = 0, n_err = 0;

  // Reference model: samples of the open window, rate chosen at window open.
  longint      qx[$], qy[$];
  int          m_l = 0;
  logic        e_vld = 1'b0;
  logic [31:0] e_x = '0, e_y = '0;

  lockin_averager dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .avg_log2(avg_log2),
    .mixed_x(mixed_x), .mixed_y(mixed_y), .mixed_valid(mixed_valid),
    .averaged_x(averaged_x), .averaged_y(averaged_y),
    .average_valid(average_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mathematical floor of s / n.
  function automatic longint fdiv(input longint s, input longint n);
    longint q;
    q = s / n;
    if ((s % n != 0) && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, average_valid}, {31'b0, e_vld});
    chk({tag, ".x"}, averaged_x, e_x);
    chk({tag, ".y"}, averaged_y, e_y);
  endtask

  // One clock with the given inputs; model advances on the same edge.
  task automatic step(input bit en, input bit v, input logic [31:0] x,
                      input logic [31:0] y, input logic [3:0] a, input string tag);
    longint sx, sy, r;
    enable = en; mixed_valid = v; mixed_x = x; mixed_y = y; avg_log2 = a;
    @(posedge clock);
    e_vld = 1'b0;
    if (!en) begin
      qx.delete(); qy.delete();
    end else if (v) begin
      if (qx.size() == 0) m_l = (a > 15) ? 15 : int'(a);
      qx.push_back(longint'($signed(x)));
      qy.push_back(longint'($signed(y)));
      if (qx.size() == (1 << m_l)) begin
        sx = 0; sy = 0;
        foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
        r = fdiv(sx, longint'(1) << m_l); e_x = r[31:0];
        r = fdiv(sy, longint'(1) << m_l); e_y = r[31:0];
        e_vld = 1'b1;
        qx.delete(); qy.delete();
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    qx.delete(); qy.delete();
    m_l = 0; e_vld = 1'b0; e_x = '0; e_y = '0;
  endtask

  initial begin
    int pulses;
    // Reset state.
    #1;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, "idle");

    // Window of 4: 10,20,30,41 -> 25.
    step(1, 1, 10, 1, 2, "w4.s0");
    step(1, 1, 20, 2, 2, "w4.s1");
    step(1, 1, 30, 3, 2, "w4.s2");
    step(1, 1, 41, 4, 2, "w4.s3");
    chk("w4.mean", averaged_x, 32'd25);
    step(1, 0, 0, 0, 2, "w4.hold");

    // Floor of negatives and full-scale without overflow.
    step(1, 1, -32'sd1, 32'h7FFFFFFF, 1, "fl.s0");
    step(1, 1, -32'sd2, 32'h7FFFFFFF, 1, "fl.s1");
    chk("floor.x", averaged_x, -32'sd2);
    chk("fullscale.y", averaged_y, 32'h7FFFFFFF);

    // L=0 pass-through, back-to-back pulses.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'(100 + i), 32'(-i), 0, "pass");
      pulses += int'(average_valid);
    end
    chk("pass.pulses", 32'(pulses), 32'd5);
    chk("pass.last", averaged_x, 32'd104);

    // Rate change mid-window is ignored until the next window.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 32'(i * 3), 32'(i), (i >= 3) ? 4'd1 : 4'd3, "rate8");
      pulses += int'(average_valid);
    end
    chk("rate8.pulses", 32'(pulses), 32'd1);
    chk("rate8.mean", averaged_x, 32'd10);
    step(1, 1, 6, 0, 1, "rate2.s0");
    step(1, 1, 9, 0, 1, "rate2.s1");
    chk("rate2.mean", averaged_x, 32'd7);

    // Partial window discarded by enable low.
    pulses = 0;
    step(1, 1, 1000, 1000, 2, "dis.s0");
    step(1, 1, 1000, 1000, 2, "dis.s1");
    step(0, 1, 1000, 1000, 2, "dis.off");
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8, 8, 2, "dis.w");
      pulses += int'(average_valid);
    end
    chk("dis.pulses", 32'(pulses), 32'd1);
    chk("dis.mean", averaged_x, 32'd8);

    // Enable falling with the closing sample: no pulse.
    step(1, 1, 5, 5, 1, "edge.s0");
    step(0, 1, 5, 5, 1, "edge.off");

    // Asynchronous reset mid-window.
    step(1, 1, 50, 50, 2, "rst.s0");
    step(1, 1, 50, 50, 2, "rst.s1");
    step(1, 1, 50, 50, 2, "rst.s2");
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst.async");
    @(posedge clock);
    #1;
    check_all("rst.held");
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4, 4, 2, "rst.w");
      pulses += int'(average_valid);
    end
    chk("rst.pulses", 32'(pulses), 32'd1);
    chk("rst.mean", averaged_x, 32'd4);

    // Random traffic with mid-window rate changes and enable drops.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7,
           $urandom, $urandom, 4'($urandom_range(0, 4)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
